// File: rtl/grant_lock_ctrl_if.sv
// grant_lock_ctrl_if: arbiter grant and channel handshake bundle for grant_lock_ctrl.
// Handshake rule: a beat transfers on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload/last until that edge.
// A sink may raise or lower ready at any time. The master modport is the side
// that drives the arbiter grant, the input channels and out_ready (the
// environment). The slave modport is the lock controller.
interface grant_lock_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] grant;
  logic         anygrant;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  modport master (
    output grant, anygrant, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_last
  );

  modport slave (
    input  grant, anygrant, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_last
  );
endinterface

// File: rtl/grant_lock_ctrl.sv
// grant_lock_ctrl: latches the arbiter winner and keeps the output channel
// locked to that input until the beat flagged last has been handshaken.
// Optional macro GRANT_CHECK_EN adds o_grant_err, a sticky flag that is set
// when the arbiter grant is malformed during an IDLE cycle.
// o_locked is the FSM state: 1 = LOCKED, 0 = IDLE.
module grant_lock_ctrl #(
  parameter int N    = 4,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  grant_lock_ctrl_if.slave     bus,
  output logic [N-1:0]         o_sel_onehot,
  output logic [$clog2(N)-1:0] o_sel_id,
  output logic                 o_locked,
  output logic                 o_release,
  output logic [CNTW-1:0]      o_beat_cnt
`ifdef GRANT_CHECK_EN
  ,output logic                o_grant_err
`endif
);
  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_sel_onehot;
  logic [IDW-1:0]  r_sel_id;
  logic [CNTW-1:0] r_beat_cnt;

  logic [N-1:0]    w_low;
  logic [IDW-1:0]  w_low_id;
  logic            w_locked;
  logic            w_out_valid;
  logic            w_out_last;
  logic [N-1:0]    w_in_ready;
  logic            w_hs;
  logic            w_release;

  // Isolate the lowest set grant bit (so a non one-hot grant still selects one input) and encode it.
  always_comb begin
    w_low    = bus.grant & (~bus.grant + ONE_N);
    w_low_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_low[i]) w_low_id = IDW'(i);
    end
  end

  // Pass valid/last/ready straight through for the selected input while locked. Nothing is buffered.
  always_comb begin
    w_locked    = (r_state == ST_LOCKED);
    w_out_valid = w_locked & bus.in_valid[r_sel_id];
    w_out_last  = w_locked & bus.in_last[r_sel_id];
    w_in_ready  = w_locked ? (r_sel_onehot & {N{bus.out_ready}}) : '0;
    w_hs        = w_out_valid & bus.out_ready;
    w_release   = w_hs & w_out_last;
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_last   = w_out_last;
  assign bus.in_ready   = w_in_ready;
  assign o_sel_onehot   = r_sel_onehot;
  assign o_sel_id       = r_sel_id;
  assign o_locked       = w_locked;
  assign o_release      = w_release;
  assign o_beat_cnt     = r_beat_cnt;

  // Lock FSM. The selection and beat count are loaded on grant. The last handshake unlocks, and id/count stay readable afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel_onehot <= '0;
      r_sel_id     <= '0;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.anygrant && (bus.grant != '0)) begin
            r_state      <= ST_LOCKED;
            r_sel_onehot <= w_low;
            r_sel_id     <= w_low_id;
            r_beat_cnt   <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_hs) begin
            if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_out_last) begin
              r_state      <= ST_IDLE;
              r_sel_onehot <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GRANT_CHECK_EN
  logic r_grant_err;
  logic w_grant_bad;

  // A grant is malformed if it is multi-hot, or if it disagrees with anygrant.
  always_comb begin
    w_grant_bad = ((bus.grant & (bus.grant - ONE_N)) != '0) ||
                  (bus.anygrant && (bus.grant == '0)) ||
                  (!bus.anygrant && (bus.grant != '0));
  end

  // Sticky error flag. It is sampled only in IDLE, because grants are ignored while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_grant_err <= 1'b0;
    else if ((r_state == ST_IDLE) && w_grant_bad) r_grant_err <= 1'b1;
  end

  assign o_grant_err = r_grant_err;
`endif
endmodule

// File: doc/grant_lock_ctrl.md
# grant_lock_ctrl

Consumer side of the fixed-priority arbiter: takes the at-most-one-hot `grant`/`anygrant` pair from the arbiter, latches the winner, and holds the output channel locked to that input for a whole multi-beat transfer. It steers valid/ready/last between N input channels and one output channel, and signals the arbiter when the transfer ends so it can re-arbitrate. It sits between the arbiter and the output-port data mux in NoC router and merger stages. The data mux itself is external and driven by `sel_onehot`/`sel_id`.

## Interface
- `N`, 4: number of input channels; N ≥ 2.
- `IDW`, $clog2(N): width of `sel_id`. Derived; do not override.
- `CNTW`, 8: width of the beat counter.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `grant`  in  N  arbiter grant; expected at-most-one-hot.
- `anygrant`  in  1  arbiter "some request present" flag.
- `in_valid`  in  N  per-input valid.
- `in_last`  in  N  per-input last-beat flag.
- `in_ready`  out  N  per-input ready.
- `out_valid`  out  1  output valid.
- `out_last`  out  1  output last.
- `out_ready`  in  1  output ready.
- `sel_onehot`  out  N  registered selection; all zeros when unlocked.
- `sel_id`  out  IDW  binary index of `sel_onehot`.
- `locked`  out  1  high while a transfer owns the output.
- `release`  out  1  one-cycle pulse on the final handshake.
- `beat_cnt`  out  CNTW  number of handshakes in the current or most recent transfer.
- `grant_err`  out  1  sticky grant-protocol error; present only with GRANT_CHECK_EN.

## Operation
- Two-state FSM: IDLE and LOCKED. `locked` = (state == LOCKED).
- **IDLE**
  - `in_ready` = 0, `out_valid` = 0, `out_last` = 0.
  - If `anygrant`=1 and `grant`≠0:
    - capture `grant & (~grant + 1)` into `sel_onehot` (lowest set bit wins if the grant is not one-hot);
    - load `sel_id` with its binary index;
    - clear `beat_cnt` to 0;
    - go to LOCKED.
  - If `anygrant`=1 and `grant`=0: stay in IDLE.
- **LOCKED**
  - `out_valid` = `in_valid[sel_id]`.
  - `out_last` = `in_last[sel_id]`.
  - `in_ready[sel_id]` = `out_ready`; all other `in_ready` bits = 0.
  - `grant`/`anygrant` are ignored.
  - Each handshake (`out_valid & out_ready`) increments `beat_cnt`, saturating at 2^CNTW−1.
  - A handshake with `out_last`=1:
    - asserts `release` combinationally in that same cycle;
    - sends the FSM to IDLE on the next edge;
    - clears `sel_onehot` to 0;
    - leaves `sel_id` and `beat_cnt` holding their values.
- `release` = LOCKED & `out_valid` & `out_ready` & `out_last`. It is never asserted in IDLE.
- Inputs other than `sel_id` may toggle `in_valid` freely; this has no effect.

## Timing
- Reset values (asynchronous): state = IDLE, `sel_onehot` = 0, `sel_id` = 0, `locked` = 0, `beat_cnt` = 0, `grant_err` = 0. Combinational outputs are therefore 0 as well.
- Reset asserted mid-transfer: the transfer is abandoned immediately. No `release` pulse is produced.
- Grant-to-lock latency is 1 cycle. A grant sampled at edge t gives `locked`=1 and pass-through of valid/ready from cycle t+1.
- Ready and valid paths in LOCKED are purely combinational. There is no internal buffering.
- Back-to-back transfers:
  - final handshake at cycle t;
  - IDLE at t+1, with grant sampled at the end of t+1;
  - LOCKED again at t+2.
  - This gives exactly one bubble cycle.
- Single-beat transfer (`in_last`=1 on the first beat): lock at t+1, handshake and `release` at t+1, IDLE at t+2. `beat_cnt` reads 1.

## Configuration
- `GRANT_CHECK_EN` defined: `grant_err` port and checker are compiled in. `grant_err` is set on any IDLE cycle where:
  - `grant` has more than one bit set, or
  - `anygrant`=1 and `grant`=0, or
  - `anygrant`=0 and `grant`≠0.
  
  Once set, it stays 1 until `rst`. It has no effect on the FSM.
- Not defined: the port and the logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: assert `rst` with random inputs → every output is 0 and state is IDLE. Assert `rst` again mid-transfer → `locked` drops asynchronously and `release` stays 0.
- N=4, `grant`=4'b0100 and `anygrant`=1 at cycle 0 → `locked`=1, `sel_id`=2, `sel_onehot`=4'b0100 at cycle 1. Only `in_ready[2]` follows `out_ready`.
- 3-beat transfer on input 1 with `out_ready` low on beat 2 for 2 cycles → exactly 3 handshakes. `release` pulses once, on the last beat. `beat_cnt`=3. `locked`=0 on the next cycle.
- Change `grant` to 4'b0001 while locked on input 3 → selection unchanged until `release`. Then IDLE for 1 cycle, then locked on input 0.
- `grant`=4'b0110 → `sel_id`=1. With GRANT_CHECK_EN, `grant_err`=1 and stays 1 until `rst`.
- CNTW=2 with a 6-beat transfer → `beat_cnt` saturates at 3. `release` is still correct on beat 6.
